// File: rtl/acc_uart_tx_pkg.sv
// Shared constants for the accumulator storage/readout/UART chain:
// one-hot transmitter states and 8N1 frame geometry.
package acc_uart_tx_pkg;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS_PER_FRAME = 8;
  localparam int BAUD_CNT_W = 16;

  // One-hot transmitter states
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    START_BIT = 5'b00010,
    DATA_BITS = 5'b00100,
    STOP_BIT  = 5'b01000,
    SETTLE    = 5'b10000
  } txState_t;

  // Terminal value of the bit timer for a given bit period
  function automatic logic [BAUD_CNT_W-1:0] lastCount(input int clksPerBit);
    return BAUD_CNT_W'(clksPerBit - 1);
  endfunction

endpackage

// File: rtl/acc_uart_tx_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// Clear restarts the bit period (used on every FSM state change).
module acc_uart_tx_baud_tick
  import acc_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic ReadClock,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  logic [BAUD_CNT_W-1:0] count;

  assign Tick = (count == lastCount(CLKS_PER_BIT));

  // Free-running period counter, reloaded on clear or terminal count
  always_ff @(posedge ReadClock or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (Clear || Tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/acc_uart_tx.sv
// 8N1 UART transmitter draining the accumulator storage stage.
// A byte is latched from DataIn in IDLE (with a one-cycle ReadEnable
// handshake), shifted out LSB first, and counted in BytesSent once its
// stop bit completes. A one-cycle SETTLE state keeps ReadEnable pulses
// at least two cycles apart so upstream's registered DataOut can update.
module acc_uart_tx
  import acc_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        ReadClock,
  input  logic        Reset,
  input  logic [7:0]  DataIn,
  input  logic        DataReady,
  output logic        ReadEnable,
  input  logic        TxEnable,
  output logic        TxOut,
  output logic        Busy,
  output logic [15:0] BytesSent
);

  txState_t    state, stateNext;
  logic [7:0]  shiftReg, shiftNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [15:0] bytesSentQ;
  logic        txNext;
  logic        latch;
  logic        sentInc;
  logic        tick;

  acc_uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .ReadClock(ReadClock),
    .Reset    (Reset),
    .Clear    (stateNext != state),
    .Tick     (tick)
  );

  // Next-state, shift/bit-index update and registered-line value
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitIdxNext = bitIdx;
    latch      = 1'b0;
    sentInc    = 1'b0;
    case (state)
      IDLE: begin
        if (DataReady && TxEnable) begin
          latch      = 1'b1;
          shiftNext  = DataIn;
          bitIdxNext = 3'd0;
          stateNext  = START_BIT;
        end
      end
      START_BIT: begin
        if (tick) stateNext = DATA_BITS;
      end
      DATA_BITS: begin
        if (tick) begin
          shiftNext  = {1'b0, shiftReg[7:1]};
          bitIdxNext = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNext = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (tick) begin
          sentInc   = 1'b1;
          stateNext = SETTLE;
        end
      end
      SETTLE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Line level for the coming cycle, so TxOut comes straight off a flop
    txNext = 1'b1;
    if (stateNext == START_BIT)
      txNext = 1'b0;
    else if (stateNext == DATA_BITS)
      txNext = shiftNext[0];
  end

  // State, datapath and output registers; reset aborts any byte in flight
  always_ff @(posedge ReadClock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitIdx     <= '0;
      TxOut      <= 1'b1;
      bytesSentQ <= '0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
      TxOut    <= txNext;
      if (sentInc) bytesSentQ <= bytesSentQ + 16'd1;
    end
  end

  // The state flop sits in IDLE during reset, so the handshake is gated
  // to keep upstream from advancing before the first clean edge.
  assign ReadEnable = latch & ~Reset;
  assign Busy       = (state != IDLE);
  assign BytesSent  = bytesSentQ;

endmodule

// File: tb/tb_acc_uart_tx.sv
// Directed bench for acc_uart_tx with a 4-cycle bit period.
module tb_acc_uart_tx;

  logic        ReadClock;
  logic        Reset;
  logic [7:0]  DataIn;
  logic        DataReady;
  logic        ReadEnable;
  logic        TxEnable;
  logic        TxOut;
  logic        Busy;
  logic [15:0] BytesSent;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lastLatch = 0;
  logic [15:0] expSent = '0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line levels in transmit order, frame[9] first
  } vec_t;

  vec_t vecs[4];
  int   latchAt[4];

  acc_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .ReadClock (ReadClock),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DataReady (DataReady),
    .ReadEnable(ReadEnable),
    .TxEnable  (TxEnable),
    .TxOut     (TxOut),
    .Busy      (Busy),
    .BytesSent (BytesSent)
  );

  initial ReadClock = 1'b0;
  always #5 ReadClock = ~ReadClock;
  always @(posedge ReadClock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for the handshake, then checks every cycle of the frame, the
  // SETTLE cycle and the byte count. New upstream inputs are applied on
  // the first START_BIT cycle; optional one-cycle DataReady dip in bit 4.
  task automatic sendFrame(input logic [9:0] frame, input logic [7:0] nextData,
                           input logic nextReady, input logic nextTxEn,
                           input logic glitch, input string name);
    int   n;
    logic ok;
    int   badBit;
    logic badVal;
    n = 0;
    #1;
    while (ReadEnable !== 1'b1 && n < 200) begin
      @(negedge ReadClock);
      #1;
      n++;
    end
    chk({name, " handshake"}, {31'd0, ReadEnable}, 32'd1);
    if (ReadEnable !== 1'b1) return;
    lastLatch = cyc;
    ok = 1'b1;
    badBit = -1;
    badVal = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge ReadClock);
        if (ok && (TxOut !== frame[9-b] || ReadEnable !== 1'b0 || Busy !== 1'b1)) begin
          ok = 1'b0;
          badBit = b;
          badVal = TxOut;
        end
        if (b == 0 && c == 0) begin
          DataIn    = nextData;
          DataReady = nextReady;
          TxEnable  = nextTxEn;
        end
        if (glitch && b == 5 && c == 0) DataReady = 1'b0;
        if (glitch && b == 5 && c == 1) DataReady = nextReady;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s frame: bit %0d TxOut=%b (or stray ReadEnable/Busy) want %b",
               name, badBit, badVal, (badBit >= 0) ? frame[9-badBit] : 1'b0);
    end
    @(negedge ReadClock);
    expSent = expSent + 16'd1;
    chk({name, " settle tx"}, {31'd0, TxOut}, 32'd1);
    chk({name, " settle re"}, {31'd0, ReadEnable}, 32'd0);
    chk({name, " count"}, {16'd0, BytesSent}, {16'd0, expSent});
  endtask

  initial begin
    vecs[0] = '{8'h80, 10'b0000000011};
    vecs[1] = '{8'h02, 10'b0010000001};
    vecs[2] = '{8'h12, 10'b0010010001};
    vecs[3] = '{8'h34, 10'b0001011001};

    // Reset state, with a byte offered during reset
    Reset = 1'b1;
    DataIn = 8'hA5;
    DataReady = 1'b1;
    TxEnable = 1'b1;
    repeat (3) @(negedge ReadClock);
    chk("reset tx", {31'd0, TxOut}, 32'd1);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset count", {16'd0, BytesSent}, 32'd0);
    chk("reset re", {31'd0, ReadEnable}, 32'd0);
    DataReady = 1'b0;
    @(negedge ReadClock);
    Reset = 1'b0;

    // Idle with no data: no handshake, line high
    for (int i = 0; i < 4; i++) begin
      @(negedge ReadClock);
      chk("idle re", {31'd0, ReadEnable}, 32'd0);
      chk("idle tx", {31'd0, TxOut}, 32'd1);
    end

    // Single byte 0xA5
    DataIn = 8'hA5;
    DataReady = 1'b1;
    sendFrame(10'b0101001011, 8'h00, 1'b0, 1'b1, 1'b0, "a5");
    @(negedge ReadClock);
    chk("post a5 busy", {31'd0, Busy}, 32'd0);

    // Reset during data bit 3 of 0x00
    DataIn = 8'h00;
    DataReady = 1'b1;
    #1;
    chk("abort handshake", {31'd0, ReadEnable}, 32'd1);
    @(negedge ReadClock);
    DataReady = 1'b0;
    repeat (17) @(negedge ReadClock);
    chk("abort pre tx", {31'd0, TxOut}, 32'd0);
    chk("abort pre busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("abort tx", {31'd0, TxOut}, 32'd1);
    chk("abort busy", {31'd0, Busy}, 32'd0);
    chk("abort count", {16'd0, BytesSent}, 32'd0);
    @(negedge ReadClock);
    Reset = 1'b0;
    expSent = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ReadClock);
      chk("abort release re", {31'd0, ReadEnable}, 32'd0);
      chk("abort release tx", {31'd0, TxOut}, 32'd1);
    end

    // Back-to-back frames, DataReady held, upstream stepping its byte
    DataIn = vecs[0].data;
    DataReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sendFrame(vecs[i].frame, (i < 3) ? vecs[i+1].data : 8'h00, i < 3, 1'b1, 1'b0,
                $sformatf("stream%0d", i));
      latchAt[i] = lastLatch;
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("spacing%0d", i), latchAt[i] - latchAt[i-1], 32'd42);
    chk("stream count", {16'd0, BytesSent}, 32'd4);

    // DataReady dip mid-frame, then TxEnable dropped during START_BIT
    @(negedge ReadClock);
    DataIn = 8'h3C;
    DataReady = 1'b1;
    sendFrame(10'b0001111001, 8'hC3, 1'b1, 1'b1, 1'b1, "dip");
    sendFrame(10'b0110000111, 8'h5A, 1'b1, 1'b0, 1'b0, "pause");
    for (int i = 0; i < 10; i++) begin
      @(negedge ReadClock);
      chk("paused re", {31'd0, ReadEnable}, 32'd0);
      chk("paused busy", {31'd0, Busy}, 32'd0);
    end
    TxEnable = 1'b1;
    #1;
    chk("resume re", {31'd0, ReadEnable}, 32'd1);
    sendFrame(10'b0010110101, 8'h00, 1'b0, 1'b1, 1'b0, "resume");

    // Byte counter wrap
    @(negedge ReadClock);
    force dut.bytesSentQ = 16'hFFFF;
    @(negedge ReadClock);
    release dut.bytesSentQ;
    @(negedge ReadClock);
    chk("preload", {16'd0, BytesSent}, 32'h0000FFFF);
    expSent = 16'hFFFF;
    DataIn = 8'h01;
    DataReady = 1'b1;
    sendFrame(10'b0100000001, 8'h00, 1'b0, 1'b1, 1'b0, "wrap");
    chk("wrap zero", {16'd0, BytesSent}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_uart_tx.md
ACC_UART_TX -- requirements
Module: acc_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning ReadClock cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have port ReadClock  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port DataIn  input  8  byte from the accumulator storage stage (its DataOut).
REQ-005 SHALL have port DataReady  input  1  high when DataIn holds a valid byte to send.
REQ-006 SHALL have port ReadEnable  output  1  one-cycle pulse: current byte consumed, upstream advances.
REQ-007 SHALL have port TxEnable  input  1  high permits starting a new byte; low pauses between bytes.
REQ-008 SHALL have port TxOut  output  1  UART serial line, idle high, 8N1, LSB first.
REQ-009 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port BytesSent  output  16  count of fully transmitted bytes, wraps 0xFFFF->0x0000.

Function
REQ-011 SHALL implement one-hot states IDLE, START_BIT, DATA_BITS, STOP_BIT, SETTLE.
REQ-012 IDLE: when DataReady & TxEnable sampled high, SHALL latch DataIn into shift register, pulse ReadEnable for exactly that one cycle, go to START_BIT.
REQ-013 ReadEnable SHALL never be high in any state other than the IDLE->START_BIT transition cycle.
REQ-014 START_BIT: TxOut=0 for CLKS_PER_BIT cycles, then DATA_BITS.
REQ-015 DATA_BITS: TxOut=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 3-bit bit index 0..7; after bit 7 go to STOP_BIT.
REQ-016 STOP_BIT: TxOut=1 for CLKS_PER_BIT cycles, then increment BytesSent and go to SETTLE.
REQ-017 SETTLE: one cycle, TxOut=1, then IDLE; guarantees >=2 cycles between ReadEnable pulses so upstream registered DataOut is stable before next latch.
REQ-018 Latency: TxOut falls on the cycle after the IDLE latch cycle; one byte occupies 10*CLKS_PER_BIT+2 cycles from latch to next possible latch.
REQ-019 Baud counter SHALL be 16 bits, count 0..CLKS_PER_BIT-1, reload to 0 on every state change.
REQ-020 DataReady falling mid-byte SHALL NOT affect the byte in flight; only sampled in IDLE.
REQ-021 TxEnable falling mid-byte SHALL let the current byte finish; no new byte starts while low.
REQ-022 DataIn changes after latch SHALL NOT affect TxOut.
REQ-023 TxOut SHALL be driven from a flop (glitch-free).

Reset
REQ-024 Reset SHALL asynchronously force state IDLE, TxOut=1, ReadEnable=0, Busy=0, BytesSent=0, shift register=0, counters=0.
REQ-025 Reset mid-byte SHALL abort the byte immediately with TxOut high; no ReadEnable pulse and no BytesSent increment on release.
REQ-026 After Reset release, first latch SHALL occur no earlier than the first rising edge with Reset low.

Structure
REQ-027 One-hot state constants and the 8N1 frame length (10) SHALL live in a shared package used with the storage/readout stages.
REQ-028 Implementation SHALL be a single module; a bit-timer sub-module baud_tick (counter + terminal-count pulse) is permitted.

Verification (CLKS_PER_BIT=4)
REQ-029 DataIn=0xA5, DataReady=1, TxEnable=1 from IDLE -> one ReadEnable pulse, TxOut sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles, BytesSent=1.
REQ-030 DataReady held high, DataIn stepping 0x80,0x02,0x12,0x34 -> four frames, ReadEnable pulses spaced 42 cycles, BytesSent=4, bytes decoded in order.
REQ-031 Reset asserted during DATA_BITS bit 3 -> TxOut=1 same cycle, BytesSent=0, no ReadEnable for 5 cycles after release with DataReady=0.
REQ-032 TxEnable dropped during START_BIT with DataReady=1 -> current frame completes, no further ReadEnable until TxEnable=1, then next frame starts within 1 cycle.
REQ-033 Preload BytesSent 0xFFFF (force), send one byte -> BytesSent=0x0000.
REQ-034 DataReady pulse low for 1 cycle mid-frame -> frame unaffected; DataReady=0 in IDLE -> no ReadEnable, TxOut stays 1.
